// File: rtl/pattern_detector_param_if.sv
// Stream bundle feeding the pattern detector: one word plus its valid qualifier.
interface pattern_detector_param_if #(
    parameter int DATA_W = 8
);
    logic              IN_VALID;
    logic [DATA_W-1:0] IN;

    modport master (output IN_VALID, output IN);
    modport slave  (input  IN_VALID, input  IN);
endinterface

// File: rtl/pattern_detector_param.sv
// Link checker: locks onto a programmable repeating pattern and counts
// mismatches once locked.
module pattern_detector_param #(
    parameter int DATA_W  = 8,
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8,
    parameter int ERR_W   = 16
) (
    input  logic                        CLK,
    input  logic                        RST,
    pattern_detector_param_if.slave     stream,
    input  logic [DATA_W*PAT_LEN-1:0]   PATTERN,
    input  logic [CNT_W-1:0]            n_pattern,
    input  logic                        CLR_ERR,
    output logic                        Pattern_Found,
    output logic [$clog2(PAT_LEN)-1:0]  Word_Idx,
    output logic [ERR_W-1:0]            Err_Count
);
    localparam int IDX_W = $clog2(PAT_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN - 1);

    typedef enum logic [1:0] {SEARCH, TRACK, FOUND} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_inc;
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic [CNT_W-1:0]   ncap_q, ncap_d, n_eff;
    logic [CNT_W:0]     rep_sum;
    logic [ERR_W-1:0]   err_q, err_d, err_inc;
    logic               found_q;
    logic [DATA_W-1:0]  cur_word;
    logic               is_w0, match, last;

    always_comb begin
        cur_word = PATTERN[DATA_W-1:0];
        for (int k = 0; k < PAT_LEN; k++) begin
            if (idx_q == IDX_W'(k)) cur_word = PATTERN[k*DATA_W +: DATA_W];
        end
    end

    assign is_w0   = (stream.IN == PATTERN[DATA_W-1:0]);
    assign match   = (stream.IN == cur_word);
    assign last    = (idx_q == LAST_IDX);
    assign idx_inc = last ? '0 : idx_q + IDX_W'(1);
    assign n_eff   = (n_pattern == '0) ? CNT_W'(1) : n_pattern;
    // One bit wider so a full-scale n_pattern can still be reached
    assign rep_sum = {1'b0, rep_q} + (CNT_W+1)'(1);
    assign err_inc = (err_q == '1) ? err_q : err_q + ERR_W'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        ncap_d  = ncap_q;
        err_d   = err_q;
        if (stream.IN_VALID) begin
            unique case (state_q)
                SEARCH: begin
                    if (is_w0) begin
                        state_d = TRACK;
                        idx_d   = IDX_W'(1);
                        rep_d   = '0;
                        ncap_d  = n_eff;
                    end
                end
                TRACK, FOUND: begin
                    if (match) begin
                        idx_d = idx_inc;
                        if (state_q == TRACK && last) begin
                            rep_d = rep_sum[CNT_W-1:0];
                            if (rep_sum == {1'b0, ncap_q}) begin
                                state_d = FOUND;
                                rep_d   = '0;
                            end
                        end
                    end else begin
                        // Re-sync: a mismatching word that equals word 0 restarts tracking
                        rep_d   = '0;
                        state_d = is_w0 ? TRACK : SEARCH;
                        idx_d   = is_w0 ? IDX_W'(1) : '0;
                        if (state_q == FOUND) err_d = err_inc;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    idx_d   = '0;
                    rep_d   = '0;
                end
            endcase
        end
        if (CLR_ERR) err_d = '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= SEARCH;
            idx_q   <= '0;
            rep_q   <= '0;
            ncap_q  <= CNT_W'(1);
            err_q   <= '0;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            ncap_q  <= ncap_d;
            err_q   <= err_d;
            found_q <= (state_d == FOUND);
        end
    end

    assign Pattern_Found = found_q;
    assign Word_Idx      = idx_q;
    assign Err_Count     = err_q;
endmodule
